// File: rtl/smc_pkg.sv
// Shared types and sizes for the SMC frame loader slice.
package smc_pkg;

  localparam int N_MOS = 6;
  localparam int DW    = 3;
  localparam int OW    = 10;

  // Index into the frame; 3 bits covers entries 0..N_MOS-1.
  typedef logic [2:0] idx_t;

  // One transistor tuple as it arrives on the input stream.
  typedef struct packed {
    logic [DW-1:0] w;
    logic [DW-1:0] vgs;
    logic [DW-1:0] vds;
  } mos_t;

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    OUT
  } state_t;

endpackage

// File: rtl/smc_frame_loader_if.sv
// Tuple input stream and result output stream of the frame loader.
interface smc_frame_loader_if;
  import smc_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_w;
  logic [DW-1:0] in_vgs;
  logic [DW-1:0] in_vds;
  logic [1:0]    in_mode;
  logic          in_abort;

  logic          res_valid;
  logic          res_ready;
  logic [OW-1:0] res_data;

  // Producer of tuples and consumer of results.
  modport master (
    output in_valid, in_w, in_vgs, in_vds, in_mode, in_abort, res_ready,
    input  in_ready, res_valid, res_data
  );

  // The loader itself.
  modport slave (
    input  in_valid, in_w, in_vgs, in_vds, in_mode, in_abort, res_ready,
    output in_ready, res_valid, res_data
  );

endinterface

// File: rtl/smc_frame_buf.sv
// N_MOS-entry register file holding the frame presented to the calculator.
module smc_frame_buf
  import smc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  idx_t          widx,
  input  mos_t          wdata,
  output logic [DW-1:0] w_arr   [N_MOS],
  output logic [DW-1:0] vgs_arr [N_MOS],
  output logic [DW-1:0] vds_arr [N_MOS]
);

  mos_t mem [N_MOS];

  // Write the addressed entry on an accepted beat; clear everything on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_MOS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_MOS; i++) begin
        if (we && (widx == idx_t'(i))) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  // Split the stored tuples into the calculator's three parallel arrays.
  always_comb begin
    for (int i = 0; i < N_MOS; i++) begin
      w_arr[i]   = mem[i].w;
      vgs_arr[i] = mem[i].vgs;
      vds_arr[i] = mem[i].vds;
    end
  end

endmodule

// File: rtl/smc_frame_loader.sv
// Sequential front end: collects a 6-tuple frame, holds it on the
// calculator inputs, samples the result and hands it out over a stream.
module smc_frame_loader
  import smc_pkg::*;
#(
  parameter int CALC_WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  smc_frame_loader_if.slave bus,
  output logic [DW-1:0] W    [N_MOS],
  output logic [DW-1:0] V_GS [N_MOS],
  output logic [DW-1:0] V_DS [N_MOS],
  output logic [1:0]    mode,
  input  logic [OW-1:0] calc_out,
  output logic [7:0]    frame_cnt,
  output logic          busy
);

  localparam int   WCW      = (CALC_WAIT > 1) ? $clog2(CALC_WAIT) : 1;
  typedef logic [WCW-1:0] wait_t;
  localparam wait_t WAIT_LAST = wait_t'(CALC_WAIT - 1);
  localparam idx_t  LAST_IDX  = idx_t'(N_MOS - 1);

  state_t        state_q;
  state_t        state_d;
  idx_t          idx;
  wait_t         wait_cnt;
  logic [OW-1:0] res_data_q;
  logic          beat_ok;
  logic          calc_done;
  logic          res_hs;
  mos_t          beat_data;

  assign beat_data    = '{w: bus.in_w, vgs: bus.in_vgs, vds: bus.in_vds};
  assign bus.res_data = res_data_q;

  smc_frame_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .we      (beat_ok),
    .widx    (idx),
    .wdata   (beat_data),
    .w_arr   (W),
    .vgs_arr (V_GS),
    .vds_arr (V_DS)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake decode; everything is masked while rst is high.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;
    busy          = 1'b0;
    beat_ok       = 1'b0;
    calc_done     = 1'b0;
    res_hs        = 1'b0;
    case (state_q)
      LOAD: begin
        bus.in_ready = !rst;
        beat_ok      = bus.in_valid && !bus.in_abort && !rst;
        if (beat_ok && (idx == LAST_IDX)) begin
          state_d = CALC;
        end
      end
      CALC: begin
        busy      = !rst;
        calc_done = (wait_cnt == WAIT_LAST);
        if (calc_done) begin
          state_d = OUT;
        end
      end
      OUT: begin
        busy          = !rst;
        bus.res_valid = !rst;
        res_hs        = bus.res_ready && !rst;
        if (res_hs) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Beat index, mode capture, settle counter, result capture and frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      wait_cnt   <= '0;
      mode       <= '0;
      res_data_q <= '0;
      frame_cnt  <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.in_abort) begin
            idx <= '0;
          end else if (beat_ok) begin
            if (idx == '0) begin
              mode <= bus.in_mode;
            end
            if (idx == LAST_IDX) begin
              idx      <= '0;
              wait_cnt <= '0;
            end else begin
              idx <= idx + idx_t'(1);
            end
          end
        end
        CALC: begin
          if (calc_done) begin
            res_data_q <= calc_out;
            wait_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt + wait_t'(1);
          end
        end
        OUT: begin
          if (res_hs) begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smc_frame_loader.sv
// Directed, table-driven bench for smc_frame_loader with CALC_WAIT = 1.
module tb_smc_frame_loader;
  import smc_pkg::*;

  typedef struct {
    logic          valid;
    logic          abort;
    logic [DW-1:0] w;
    logic [DW-1:0] vgs;
    logic [DW-1:0] vds;
    logic [1:0]    md;
    logic          exp_ready;
    logic          exp_rvalid;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] W    [N_MOS];
  logic [DW-1:0] V_GS [N_MOS];
  logic [DW-1:0] V_DS [N_MOS];
  logic [1:0]    mode;
  logic [OW-1:0] calc_out;
  logic [7:0]    frame_cnt;
  logic          busy;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];
  logic [7:0] exp_cnt;

  smc_frame_loader_if bus();

  smc_frame_loader #(.CALC_WAIT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .W         (W),
    .V_GS      (V_GS),
    .V_DS      (V_DS),
    .mode      (mode),
    .calc_out  (calc_out),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int tag, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s[%0d] actual=%0d expected=%0d", name, tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.in_valid = v.valid;
    bus.in_abort = v.abort;
    bus.in_w     = v.w;
    bus.in_vgs   = v.vgs;
    bus.in_vds   = v.vds;
    bus.in_mode  = v.md;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      applyStimulus(vecs[k]);
      tick();
      checkOutput("vec_in_ready", k, 32'(bus.in_ready), 32'(vecs[k].exp_ready));
      checkOutput("vec_res_valid", k, 32'(bus.res_valid), 32'(vecs[k].exp_rvalid));
    end
    bus.in_valid = 1'b0;
    bus.in_abort = 1'b0;
  endtask

  // Load a full frame, wait a bounded time for the result and accept it.
  task automatic run_frame(input logic [DW-1:0] v, input int tag);
    int waited;
    for (int b = 0; b < N_MOS; b++) begin
      applyStimulus('{1'b1, 1'b0, v, v, v, 2'd0, 1'b0, 1'b0});
      tick();
    end
    bus.in_valid = 1'b0;
    waited = 0;
    while (bus.res_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("frame_res_valid", tag, 32'(bus.res_valid), 32'd1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.in_abort  = 1'b0;
    bus.in_w      = 3'd5;
    bus.in_vgs    = 3'd5;
    bus.in_vds    = 3'd5;
    bus.in_mode   = 2'd3;
    bus.res_ready = 1'b0;
    calc_out      = 10'd123;

    // Reset held for two cycles with in_valid high.
    tick();
    tick();
    checkOutput("rst_in_ready", 0, 32'(bus.in_ready), 32'd0);
    checkOutput("rst_res_valid", 0, 32'(bus.res_valid), 32'd0);
    checkOutput("rst_busy", 0, 32'(busy), 32'd0);
    checkOutput("rst_frame_cnt", 0, 32'(frame_cnt), 32'd0);
    checkOutput("rst_mode", 0, 32'(mode), 32'd0);
    checkOutput("rst_res_data", 0, 32'(bus.res_data), 32'd0);
    for (int i = 0; i < N_MOS; i++) begin
      checkOutput("rst_arrays", i, 32'({W[i], V_GS[i], V_DS[i]}), 32'd0);
    end
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checkOutput("rel_in_ready", 0, 32'(bus.in_ready), 32'd1);

    // Back-to-back full frame, mode only taken from beat 0.
    for (int b = 0; b < N_MOS; b++) begin
      applyStimulus('{1'b1, 1'b0, 3'd2, 3'd3, 3'd4, (b == 0) ? 2'd3 : 2'd0, 1'b0, 1'b0});
      tick();
    end
    bus.in_valid = 1'b0;
    checkOutput("calc_res_valid", 0, 32'(bus.res_valid), 32'd0);
    checkOutput("calc_in_ready", 0, 32'(bus.in_ready), 32'd0);
    checkOutput("calc_busy", 0, 32'(busy), 32'd1);
    tick();
    checkOutput("out_res_valid", 0, 32'(bus.res_valid), 32'd1);
    checkOutput("out_res_data", 0, 32'(bus.res_data), 32'd123);
    checkOutput("out_mode", 0, 32'(mode), 32'd3);
    for (int i = 0; i < N_MOS; i++) begin
      checkOutput("f1_arrays", i, 32'({W[i], V_GS[i], V_DS[i]}), 32'({3'd2, 3'd3, 3'd4}));
    end

    // Hold the result with res_ready low while calc_out and in_valid wiggle.
    calc_out      = 10'd999;
    bus.in_valid  = 1'b1;
    bus.in_w      = 3'd7;
    bus.in_vgs    = 3'd7;
    bus.in_vds    = 3'd7;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("bp_res_valid", c, 32'(bus.res_valid), 32'd1);
      checkOutput("bp_res_data", c, 32'(bus.res_data), 32'd123);
      checkOutput("bp_in_ready", c, 32'(bus.in_ready), 32'd0);
    end
    checkOutput("bp_arrays", 0, 32'({W[0], V_GS[0], V_DS[0]}), 32'({3'd2, 3'd3, 3'd4}));
    checkOutput("bp_arrays", 5, 32'({W[5], V_GS[5], V_DS[5]}), 32'({3'd2, 3'd3, 3'd4}));
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checkOutput("hs_frame_cnt", 1, 32'(frame_cnt), 32'd1);
    checkOutput("hs_in_ready", 1, 32'(bus.in_ready), 32'd1);
    checkOutput("hs_res_valid", 1, 32'(bus.res_valid), 32'd0);

    // Vector tables: gapped frame (0..11), abort sequence (12..22).
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) begin
        vecs.push_back('{1'b1, 1'b0, 3'(k / 2), 3'(k / 2 + 1), 3'(7 - k / 2),
                         (k == 0) ? 2'd1 : 2'd2, (k < 10), 1'b0});
      end else begin
        vecs.push_back('{1'b0, 1'b0, 3'd7, 3'd7, 3'd7, 2'd3, (k < 10), (k == 11)});
      end
    end
    vecs.push_back('{1'b1, 1'b0, 3'd4, 3'd4, 3'd4, 2'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd4, 3'd4, 3'd4, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'd4, 3'd4, 3'd4, 2'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 3'd7, 3'd7, 3'd7, 2'd3, 1'b1, 1'b0});
    for (int b = 0; b < N_MOS; b++) begin
      vecs.push_back('{1'b1, 1'b0, 3'd1, 3'd1, 3'd1, (b == 0) ? 2'd2 : 2'd0, (b < 5), 1'b0});
    end
    vecs.push_back('{1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1});

    // Gapped frame with mode taken from beat 0 only.
    calc_out = 10'd321;
    run_table(0, 11);
    checkOutput("gap_w5", 0, 32'(W[5]), 32'd5);
    checkOutput("gap_vds0", 0, 32'(V_DS[0]), 32'd7);
    checkOutput("gap_vgs2", 0, 32'(V_GS[2]), 32'd3);
    checkOutput("gap_mode", 0, 32'(mode), 32'd1);
    checkOutput("gap_res_data", 0, 32'(bus.res_data), 32'd321);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    checkOutput("gap_frame_cnt", 0, 32'(frame_cnt), 32'd2);

    // Abort after three beats; the abort-cycle tuple must not land in entry 3.
    calc_out = 10'd55;
    run_table(12, 15);
    checkOutput("abort_w3_kept", 0, 32'({W[3], V_GS[3], V_DS[3]}), 32'({3'd3, 3'd4, 3'd4}));
    checkOutput("abort_w0_new", 0, 32'(W[0]), 32'd4);
    run_table(16, 22);
    for (int i = 0; i < N_MOS; i++) begin
      checkOutput("abort_arrays", i, 32'({W[i], V_GS[i], V_DS[i]}), 32'({3'd1, 3'd1, 3'd1}));
    end
    checkOutput("abort_mode", 0, 32'(mode), 32'd2);
    checkOutput("abort_res_data", 0, 32'(bus.res_data), 32'd55);
    bus.res_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.res_ready = 1'b0;
    checkOutput("abort_one_result", 0, 32'(bus.res_valid), 32'd0);
    checkOutput("abort_frame_cnt", 0, 32'(frame_cnt), 32'd3);

    // Run to 256 completed frames so the counter wraps to zero.
    exp_cnt = 8'd3;
    for (int f = 0; f < 253; f++) begin
      run_frame(3'(f), f);
      exp_cnt = exp_cnt + 8'd1;
      checkOutput("wrap_frame_cnt", f, 32'(frame_cnt), 32'(exp_cnt));
    end
    checkOutput("wrap_zero", 0, 32'(frame_cnt), 32'd0);

    // Reset while the frame is in CALC: no result, everything cleared.
    for (int b = 0; b < N_MOS; b++) begin
      applyStimulus('{1'b1, 1'b0, 3'd6, 3'd6, 3'd6, 2'd3, 1'b0, 1'b0});
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    checkOutput("midrst_in_calc", 0, 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy_rst", 0, 32'(busy), 32'd0);
    tick();
    checkOutput("midrst_res_valid", 0, 32'(bus.res_valid), 32'd0);
    checkOutput("midrst_in_ready", 0, 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < N_MOS; i++) begin
      checkOutput("midrst_arrays", i, 32'({W[i], V_GS[i], V_DS[i]}), 32'd0);
    end
    rst = 1'b0;
    #1;
    checkOutput("midrst_load", 0, 32'(bus.in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("midrst_no_result", c, 32'(bus.res_valid), 32'd0);
    end
    checkOutput("midrst_frame_cnt", 0, 32'(frame_cnt), 32'd0);
    bus.res_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/smc_frame_loader.md
Name: smc_frame_loader

Overview:
- Sequential front end for the combinational SMC MOSFET calculator.
- Accepts one transistor tuple (W, V_GS, V_DS) per beat over a valid/ready stream and assembles a 6-transistor frame plus mode.
- Drives the frame onto the calculator's parallel array inputs and holds it stable, then samples the calculator's 10-bit out_n.
- Returns the result over a valid/ready result port.

Parameters:
N_MOS, 6, transistors per frame
DW, 3, width of W / V_GS / V_DS fields
OW, 10, calculator result width
CALC_WAIT, 1, cycles the frame is held stable before calc_out is sampled; legal range >= 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  tuple valid
in_ready  output  1  loader accepts tuple
in_w  input  DW  transistor width
in_vgs  input  DW  gate-source voltage
in_vds  input  DW  drain-source voltage
in_mode  input  2  frame mode; sampled on beat 0 only
in_abort  input  1  discard partially loaded frame
W  output  DW x N_MOS  array to calculator
V_GS  output  DW x N_MOS  array to calculator
V_DS  output  DW x N_MOS  array to calculator
mode  output  2  mode to calculator
calc_out  input  OW  calculator out_n
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_data  output  OW  captured result
frame_cnt  output  8  completed result handshakes, wraps 255->0
busy  output  1  high in CALC or OUT

Behaviour:
- Reset: state LOAD, idx=0, wait_cnt=0.
  - W/V_GS/V_DS all entries 0, mode=0, res_data=0, res_valid=0, frame_cnt=0.
  - in_ready=0 and busy=0 in any cycle where rst=1.
  - Reset mid-frame or mid-result discards everything; nothing is emitted.
- States: LOAD, CALC, OUT. Output decode:
  - in_ready = (state==LOAD) & !rst.
  - busy = state!=LOAD.
  - res_valid = state==OUT.
- LOAD:
  - Beat accepted when in_valid & in_ready.
  - Accepted beat writes entry idx of W/V_GS/V_DS; if idx==0, also registers in_mode into mode. idx then increments.
  - Accepting the beat at idx==N_MOS-1 sets idx=0, wait_cnt=0, and goes to CALC.
- in_abort (LOAD only):
  - Forces idx=0; any beat presented in the same cycle is dropped, not written.
  - Array contents are left as-is and are overwritten by the next frame.
  - Ignored in CALC and OUT.
- CALC:
  - Arrays and mode are held constant.
  - On each edge: if wait_cnt==CALC_WAIT-1, res_data<=calc_out and go to OUT; else wait_cnt++.
  - res_valid therefore rises exactly CALC_WAIT cycles after the cycle in which the last beat was accepted.
- OUT:
  - res_valid=1; res_data and arrays are stable until the handshake.
  - On res_valid & res_ready: frame_cnt++ (8-bit wrap), go to LOAD.
  - in_ready becomes 1 in the following cycle; there is no overlap of result and load.
- Backpressure: in_valid is don't-care outside LOAD. res_ready low holds OUT indefinitely.
- No arithmetic beyond counters. idx is 3-bit and never exceeds N_MOS-1. calc_out is sampled only at the CALC exit edge; its value during LOAD is ignored.

Decomposition:
- Package smc_pkg holds:
  - localparams N_MOS, DW, OW;
  - typedef mos_t (packed struct w, vgs, vds);
  - enum state_t {LOAD, CALC, OUT};
  - typedef idx_t (logic [2:0]).
- Sub-module smc_frame_buf: N_MOS-entry mos_t register file.
  - Synchronous write port (we, widx, data) with reset-to-zero.
  - Continuously drives the three unpacked output arrays.
- The FSM, counters and handshake live in smc_frame_loader.

Test Plan:
1. Reset: rst high 2 cycles with in_valid=1 -> in_ready=0, res_valid=0, all arrays 0, frame_cnt=0; after release in_ready=1 in the first cycle.
2. Full frame, CALC_WAIT=1: beats (W,VGS,VDS)=(2,3,4) x6 back-to-back, in_mode=2'b11 on beat 0, bench calc_out=10'd123.
   - Expected: W[i]=2, V_GS[i]=3, V_DS[i]=4, mode=3.
   - res_valid rises 1 cycle after the last beat, with res_data=123.
   - res_ready=1 -> frame_cnt=1, in_ready=1 next cycle.
3. Gapped input with mode capture: in_valid toggles 1/0, beat i=(i,i+1,7-i), in_mode=2'b01 on beat 0 and 2'b10 on later beats.
   - Expected: W[5]=5, V_DS[0]=7, mode=1; no result until beat 6.
4. Abort: 3 beats accepted, then in_abort=1 with in_valid=1 and tuple (7,7,7), then 6 beats of (1,1,1).
   - Expected: abort-cycle tuple not written; all entries end 1; exactly one result.
5. Backpressure: res_ready=0 for 10 cycles in OUT while the bench changes calc_out to 10'd999 and drives in_valid=1.
   - Expected: res_data stays 123, in_ready=0, arrays unchanged; handshake after res_ready=1.
6. Wrap and reset mid-operation: 256 frames -> frame_cnt returns to 0.
   - rst asserted in CALC -> no res_valid; state LOAD, arrays 0.
